// File: rtl/image_stats_pkg.sv
// Shared types for the image_stats zone scheduler.
// Zone entries, scheduler states and the zone index width helper.
package image_stats_pkg;

  typedef struct packed {
    logic [15:0] trim_left;
    logic [15:0] width;
    logic [15:0] trim_top;
    logic [15:0] height;
  } zone_cfg_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ARM,
    WAIT_SOF,
    IN_FRAME,
    WAIT_RES
  } zs_state_e;

  function automatic int zone_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/image_stats_zone_sched_table.sv
// ROI zone table: one write port, combinational read port.
// Entries reset to the full-frame window.
module zone_cfg_table
  import image_stats_pkg::*;
#(
  parameter int NUM_ZONES = 4,
  parameter int ZW        = 2,
  parameter int MAX_COLS  = 1920,
  parameter int MAX_ROWS  = 1080
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we_i,
  input  logic [ZW-1:0]   wr_idx_i,
  input  zone_cfg_t       wr_data_i,
  input  logic [ZW-1:0]   rd_idx_i,
  output zone_cfg_t       rd_data_o
);

  localparam zone_cfg_t RST = '{
    trim_left: 16'd0,
    width:     16'(MAX_COLS - 1),
    trim_top:  16'd0,
    height:    16'(MAX_ROWS - 1)
  };

  zone_cfg_t tbl_q [NUM_ZONES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ZONES; i++) tbl_q[i] <= RST;
    end else if (we_i && (32'(wr_idx_i) < NUM_ZONES)) begin
      tbl_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = tbl_q[rd_idx_i];

endmodule

// File: rtl/image_stats_zone_sched.sv
// Time-multiplexes one image_stats block over several ROI zones,
// one zone per frame, and streams zone-tagged averages out.
module image_stats_zone_sched
  import image_stats_pkg::*;
#(
  parameter int NUM_ZONES      = 4,
  parameter int MAX_COLS       = 1920,
  parameter int MAX_ROWS       = 1080,
  parameter int ACCUM_OUT_BITS = 10,
  localparam int ZW = zone_w(NUM_ZONES),
  localparam int CW = $clog2(MAX_COLS),
  localparam int RW = $clog2(MAX_ROWS),
  localparam int AB = ACCUM_OUT_BITS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [ZW:0]   zone_count,
  input  logic          cfg_we,
  input  logic [ZW-1:0] cfg_zone,
  input  logic [CW-1:0] cfg_trim_left,
  input  logic [CW-1:0] cfg_width,
  input  logic [RW-1:0] cfg_trim_top,
  input  logic [RW-1:0] cfg_height,
  input  logic          i_fv,
  output logic [CW-1:0] trim_left,
  output logic [CW-1:0] width,
  output logic [RW-1:0] trim_top,
  output logic [RW-1:0] height,
  input  logic          avg_valid,
  input  logic [AB-1:0] ch0_avg,
  input  logic [AB-1:0] ch1_avg,
  input  logic [AB-1:0] ch2_avg,
  input  logic [AB-1:0] ch3_avg,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [ZW-1:0] res_zone,
  output logic [15:0]   res_frame,
  output logic [AB-1:0] res_ch0,
  output logic [AB-1:0] res_ch1,
  output logic [AB-1:0] res_ch2,
  output logic [AB-1:0] res_ch3,
  output logic          busy,
  output logic [7:0]    overrun_cnt
);

  zs_state_e     state_q, state_d;
  logic          fv_q, sof;
  logic [ZW-1:0] zone_q, zone_d;
  logic [ZW:0]   zc_eff, zone_inc;
  logic [15:0]   frame_q;
  logic          arm, cap, load;
  zone_cfg_t     wr_cfg, rd_cfg;

  logic [CW-1:0] tl_q, w_q;
  logic [RW-1:0] tt_q, h_q;
  logic          rv_q;
  logic [ZW-1:0] rz_q;
  logic [15:0]   rf_q;
  logic [AB-1:0] r0_q, r1_q, r2_q, r3_q;
  logic [7:0]    ovr_q;

  assign wr_cfg = '{
    trim_left: 16'(cfg_trim_left),
    width:     16'(cfg_width),
    trim_top:  16'(cfg_trim_top),
    height:    16'(cfg_height)
  };

  zone_cfg_table #(
    .NUM_ZONES (NUM_ZONES),
    .ZW        (ZW),
    .MAX_COLS  (MAX_COLS),
    .MAX_ROWS  (MAX_ROWS)
  ) u_tbl (
    .clk       (clk),
    .reset_n   (reset_n),
    .we_i      (cfg_we),
    .wr_idx_i  (cfg_zone),
    .wr_data_i (wr_cfg),
    .rd_idx_i  (zone_q),
    .rd_data_o (rd_cfg)
  );

  assign sof = i_fv & ~fv_q;

  // 0 behaves as 1 zone; oversize counts clamp to the table depth
  always_comb begin
    zc_eff = zone_count;
    if (zone_count == '0)
      zc_eff = (ZW+1)'(1);
    else if (32'(zone_count) > NUM_ZONES)
      zc_eff = (ZW+1)'(NUM_ZONES);
  end

  always_comb begin
    zone_inc = {1'b0, zone_q} + (ZW+1)'(1);
    zone_d   = (zone_inc >= zc_eff) ? '0 : zone_inc[ZW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fv_q    <= i_fv;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (enable) state_d = SYNC;
      SYNC:     if (!i_fv) state_d = ARM;
      ARM:      state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (!enable)   state_d = IDLE;
        else if (fv_q) state_d = SYNC;
        else if (sof)  state_d = IN_FRAME;
      end
      IN_FRAME: if (!i_fv) state_d = WAIT_RES;
      WAIT_RES: if (avg_valid) state_d = enable ? ARM : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    arm  = (state_q == ARM);
    cap  = (state_q == WAIT_RES) && avg_valid;
    load = cap && (!rv_q || res_ready);
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tl_q    <= '0;
      w_q     <= CW'(MAX_COLS - 1);
      tt_q    <= '0;
      h_q     <= RW'(MAX_ROWS - 1);
      zone_q  <= '0;
      frame_q <= '0;
    end else begin
      if (arm) begin
        tl_q <= rd_cfg.trim_left[CW-1:0];
        w_q  <= rd_cfg.width[CW-1:0];
        tt_q <= rd_cfg.trim_top[RW-1:0];
        h_q  <= rd_cfg.height[RW-1:0];
      end
      if (cap) begin
        zone_q  <= zone_d;
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  // a held result is never overwritten; the newcomer is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv_q  <= 1'b0;
      rz_q  <= '0;
      rf_q  <= '0;
      r0_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      ovr_q <= '0;
    end else if (load) begin
      rv_q <= 1'b1;
      rz_q <= zone_q;
      rf_q <= frame_q;
      r0_q <= ch0_avg;
      r1_q <= ch1_avg;
      r2_q <= ch2_avg;
      r3_q <= ch3_avg;
    end else begin
      if (cap && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
      if (rv_q && res_ready) rv_q <= 1'b0;
    end
  end

  assign trim_left   = tl_q;
  assign width       = w_q;
  assign trim_top    = tt_q;
  assign height      = h_q;
  assign res_valid   = rv_q;
  assign res_zone    = rz_q;
  assign res_frame   = rf_q;
  assign res_ch0     = r0_q;
  assign res_ch1     = r1_q;
  assign res_ch2     = r2_q;
  assign res_ch3     = r3_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_image_stats_zone_sched.sv
// Directed bench for image_stats_zone_sched.
// Drives frame timing and averages directly; checks windows and results.
module tb_image_stats_zone_sched;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        enable = 0;
  logic [2:0]  zone_count = 3'd2;
  logic        cfg_we = 0;
  logic [1:0]  cfg_zone = 0;
  logic [10:0] cfg_trim_left = 0, cfg_width = 0;
  logic [10:0] cfg_trim_top = 0, cfg_height = 0;
  logic        i_fv = 0;
  logic [10:0] trim_left, width, trim_top, height;
  logic        avg_valid = 0;
  logic [9:0]  ch0 = 0, ch1 = 0, ch2 = 0, ch3 = 0;
  logic        res_valid, res_ready = 0;
  logic [1:0]  res_zone;
  logic [15:0] res_frame;
  logic [9:0]  res_ch0, res_ch1, res_ch2, res_ch3;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int checks = 0;
  int errors = 0;
  logic [10:0] wl, ww, wt, wh;

  image_stats_zone_sched dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .zone_count(zone_count), .cfg_we(cfg_we),
    .cfg_zone(cfg_zone), .cfg_trim_left(cfg_trim_left),
    .cfg_width(cfg_width), .cfg_trim_top(cfg_trim_top),
    .cfg_height(cfg_height), .i_fv(i_fv),
    .trim_left(trim_left), .width(width),
    .trim_top(trim_top), .height(height),
    .avg_valid(avg_valid), .ch0_avg(ch0), .ch1_avg(ch1),
    .ch2_avg(ch2), .ch3_avg(ch3), .res_valid(res_valid),
    .res_ready(res_ready), .res_zone(res_zone),
    .res_frame(res_frame), .res_ch0(res_ch0),
    .res_ch1(res_ch1), .res_ch2(res_ch2), .res_ch3(res_ch3),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] z, input int l, input int w,
                         input int t, input int h);
    cfg_zone      = z;
    cfg_trim_left = 11'(l);
    cfg_width     = 11'(w);
    cfg_trim_top  = 11'(t);
    cfg_height    = 11'(h);
  endtask

  task automatic wr_cfg(input logic [1:0] z, input int l, input int w,
                        input int t, input int h);
    set_cfg(z, l, w, t, h);
    cfg_we = 1;
    tick();
    cfg_we = 0;
  endtask

  task automatic restart(input bit en, input logic [2:0] zc);
    reset_n = 0; enable = 0; i_fv = 0; avg_valid = 0;
    res_ready = 0; cfg_we = 0; zone_count = zc;
    repeat (2) tick();
    reset_n = 1;
    tick();
    if (en) begin
      enable = 1;
      repeat (5) tick();
    end
  endtask

  // one frame of len lines, then averages base..base+3 after 2 clk
  task automatic run_frame(input int len, input logic [9:0] base,
                           input bit mid_wr);
    i_fv = 1;
    for (int i = 0; i < len; i++) begin
      tick();
      if (mid_wr && i == 1) cfg_we = 1;
      if (mid_wr && i == 2) cfg_we = 0;
      if (i == len / 2) begin
        wl = trim_left; ww = width; wt = trim_top; wh = height;
      end
    end
    i_fv = 0;
    repeat (2) tick();
    avg_valid = 1;
    ch0 = base; ch1 = base + 10'd1;
    ch2 = base + 10'd2; ch3 = base + 10'd3;
    tick();
    avg_valid = 0;
    repeat (4) tick();
  endtask

  task automatic chk_win(input string tag, input int l, input int w,
                         input int t, input int h);
    chk({tag, ".left"}, 32'(wl), 32'(l));
    chk({tag, ".width"}, 32'(ww), 32'(w));
    chk({tag, ".top"}, 32'(wt), 32'(t));
    chk({tag, ".height"}, 32'(wh), 32'(h));
  endtask

  task automatic chk_held(input string tag, input int z, input int f,
                          input logic [9:0] base);
    chk({tag, ".valid"}, 32'(res_valid), 1);
    chk({tag, ".zone"}, 32'(res_zone), 32'(z));
    chk({tag, ".frame"}, 32'(res_frame), 32'(f));
    chk({tag, ".ch0"}, 32'(res_ch0), 32'(base));
    chk({tag, ".ch3"}, 32'(res_ch3), 32'(base + 10'd3));
  endtask

  task automatic accept(input string tag, input int z, input int f,
                        input logic [9:0] base);
    chk_held(tag, z, f, base);
    res_ready = 1;
    tick();
    res_ready = 0;
    chk({tag, ".cleared"}, 32'(res_valid), 0);
  endtask

  initial begin
    // reset state
    restart(0, 3'd2);
    chk("rst.left", 32'(trim_left), 0);
    chk("rst.width", 32'(width), 1919);
    chk("rst.top", 32'(trim_top), 0);
    chk("rst.height", 32'(height), 1079);
    chk("rst.valid", 32'(res_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.ovr", 32'(overrun_cnt), 0);

    // 1: two zones over three frames
    wr_cfg(2'd0, 10, 100, 20, 50);
    wr_cfg(2'd1, 200, 64, 300, 32);
    enable = 1;
    repeat (5) tick();
    chk("t1.busy", 32'(busy), 1);
    run_frame(8, 10'd40, 0);
    chk_win("t1.f0", 10, 100, 20, 50);
    accept("t1.r0", 0, 0, 10'd40);
    run_frame(8, 10'd80, 0);
    chk_win("t1.f1", 200, 64, 300, 32);
    accept("t1.r1", 1, 1, 10'd80);
    run_frame(8, 10'd120, 0);
    chk_win("t1.f2", 10, 100, 20, 50);
    accept("t1.r2", 0, 2, 10'd120);

    // 2: enable mid-frame skips that frame
    restart(0, 3'd2);
    i_fv = 1;
    repeat (2) tick();
    enable = 1;
    repeat (4) tick();
    i_fv = 0;
    repeat (2) tick();
    avg_valid = 1; ch0 = 10'd999;
    tick();
    avg_valid = 0;
    repeat (4) tick();
    chk("t2.skipped", 32'(res_valid), 0);
    run_frame(8, 10'd7, 0);
    accept("t2.r0", 0, 0, 10'd7);

    // 3: backpressure for three frames
    restart(1, 3'd2);
    run_frame(6, 10'd100, 0);
    chk_held("t3.a", 0, 0, 10'd100);
    run_frame(6, 10'd200, 0);
    chk_held("t3.b", 0, 0, 10'd100);
    run_frame(6, 10'd300, 0);
    chk("t3.ovr", 32'(overrun_cnt), 2);
    accept("t3.r", 0, 0, 10'd100);

    // 4: rewrite the active zone mid-frame
    restart(0, 3'd2);
    wr_cfg(2'd0, 1, 2, 3, 4);
    wr_cfg(2'd1, 5, 6, 7, 8);
    enable = 1;
    repeat (5) tick();
    run_frame(8, 10'd1, 0);
    accept("t4.r0", 0, 0, 10'd1);
    set_cfg(2'd1, 500, 600, 700, 800);
    run_frame(8, 10'd2, 1);
    chk_win("t4.f1old", 5, 6, 7, 8);
    accept("t4.r1", 1, 1, 10'd2);
    run_frame(8, 10'd3, 0);
    chk_win("t4.f2", 1, 2, 3, 4);
    accept("t4.r2", 0, 2, 10'd3);
    run_frame(8, 10'd4, 0);
    chk_win("t4.f3new", 500, 600, 700, 800);
    accept("t4.r3", 1, 3, 10'd4);

    // 5: zone_count 0 and 3
    restart(1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      run_frame(6, 10'(i), 0);
      accept("t5.zc0", 0, i, 10'(i));
    end
    restart(1, 3'd3);
    for (int i = 0; i < 4; i++) begin
      run_frame(6, 10'(i + 50), 0);
      accept("t5.zc3", (i == 3) ? 0 : i, i, 10'(i + 50));
    end
    chk_win("t5.z0win", 0, 1919, 0, 1079);

    // 6: async reset in the middle of a frame
    restart(0, 3'd2);
    wr_cfg(2'd0, 33, 44, 55, 66);
    enable = 1;
    repeat (5) tick();
    i_fv = 1;
    repeat (3) tick();
    chk("t6.win.pre", 32'(trim_left), 33);
    reset_n = 0;
    #2;
    chk("t6.left", 32'(trim_left), 0);
    chk("t6.width", 32'(width), 1919);
    chk("t6.height", 32'(height), 1079);
    chk("t6.busy", 32'(busy), 0);
    chk("t6.valid", 32'(res_valid), 0);
    tick();
    reset_n = 1;
    tick();
    repeat (3) tick();
    i_fv = 0;
    repeat (2) tick();
    avg_valid = 1;
    tick();
    avg_valid = 0;
    repeat (4) tick();
    chk("t6.novalid", 32'(res_valid), 0);
    run_frame(8, 10'd9, 0);
    accept("t6.r0", 0, 0, 10'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
